// File: rtl/ccff_chain_loader.sv
// Serializes configuration words MSB-first into a ccff chain and captures the displaced bits as readback words.
// Latency: first shift_en one cycle after the first word is accepted; done and the final rb_valid one cycle after the last shift.
// Backpressure: word_ready drops while the hold register is full or all words of the load are in; an empty buffer stalls the chain.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 16,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              shift_en,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done
);

   localparam int NW = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int AW = $clog2(NW + 1);
   localparam int PW = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic              hold_vld;
   logic [WORD_W-1:0] hold_dat;
   logic [WORD_W-1:0] sh_dat;
   logic [WORD_W-1:0] rb_sh;
   logic [WORD_W-1:0] rb_q;
   logic              rb_vld_q;
   logic              head_q;
   logic [PW-1:0]     pos;       // bit index within the current word; 0 means the next bit comes from hold
   logic [CNT_W-1:0]  bit_cnt;
   logic [AW-1:0]     acc_cnt;
   logic              bit_avail;
   logic              cur_bit;
   logic              last_bit;
   logic              accept;
   logic              word_end;
   logic [WORD_W-1:0] rb_next;

   // State register.
   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // Next state and handshake/shift controls; the first bit of a word is taken straight from hold, avoiding a load bubble.
   always_comb begin
      state_d    = state_q;
      word_ready = 1'b0;
      shift_en   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      bit_avail  = (pos != '0) || hold_vld;
      cur_bit    = (pos != '0) ? sh_dat[WORD_W-1] : hold_dat[WORD_W-1];
      last_bit   = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy       = 1'b1;
            word_ready = !hold_vld && (acc_cnt < AW'(NW));
            shift_en   = bit_avail;
            if (bit_avail && last_bit) state_d = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept    = word_valid && word_ready;
   assign word_end  = (pos == PW'(WORD_W - 1)) || last_bit;
   // A partial final word is left-aligned by pushing the unused low positions out of the top.
   assign rb_next   = {rb_sh[WORD_W-2:0], ccff_tail} << (PW'(WORD_W - 1) - pos);
   assign ccff_head = shift_en ? cur_bit : head_q;
   assign rb_data   = rb_q;
   assign rb_valid  = rb_vld_q;

   // Word buffering, serialization, bit counting and readback capture.
   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         hold_vld <= 1'b0;
         hold_dat <= '0;
         sh_dat   <= '0;
         rb_sh    <= '0;
         rb_q     <= '0;
         rb_vld_q <= 1'b0;
         head_q   <= 1'b0;
         pos      <= '0;
         bit_cnt  <= '0;
         acc_cnt  <= '0;
      end else begin
         rb_vld_q <= 1'b0;
         if (state_q == IDLE) begin
            hold_vld <= 1'b0;
            pos      <= '0;
            bit_cnt  <= '0;
            acc_cnt  <= '0;
         end else begin
            // Accept needs an empty hold, consuming hold needs a full one, so these never collide.
            if (accept) begin
               hold_vld <= 1'b1;
               hold_dat <= word_data;
               acc_cnt  <= acc_cnt + AW'(1);
            end
            if (shift_en) begin
               head_q  <= cur_bit;
               rb_sh   <= {rb_sh[WORD_W-2:0], ccff_tail};
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (pos == '0) begin
                  sh_dat   <= hold_dat << 1;
                  hold_vld <= 1'b0;
               end else begin
                  sh_dat <= sh_dat << 1;
               end
               pos <= (pos == PW'(WORD_W - 1)) ? '0 : pos + PW'(1);
               if (word_end) begin
                  rb_q     <= rb_next;
                  rb_vld_q <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 16-bit and a 12-bit instance, each feeding a behavioural chain register.
// Table of loads (fixed vectors plus random words with model-derived expectations), then idle and mid-load reset sequences.
module tb_ccff_chain_loader;

   logic       prog_clk   = 1'b0;
   logic       prog_reset = 1'b0;
   logic       start      = 1'b0;
   logic       word_valid = 1'b0;
   logic [7:0] word_data  = 8'h00;
   logic       sel        = 1'b0;   // 0: 16-bit instance, 1: 12-bit instance

   int checks   = 0;
   int failures = 0;

   always #5 prog_clk = ~prog_clk;

   logic       start16, start12, wv16, wv12;
   logic       rdy16, head16, tail16, sh16, rbv16, busy16, done16;
   logic       rdy12, head12, tail12, sh12, rbv12, busy12, done12;
   logic [7:0] rb16, rb12;
   logic [15:0] chain16 = 16'h0;
   logic [11:0] chain12 = 12'h0;

   assign start16 = start & ~sel;
   assign start12 = start & sel;
   assign wv16    = word_valid & ~sel;
   assign wv12    = word_valid & sel;

   ccff_chain_loader u16 (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start16), .word_data(word_data),
      .word_valid(wv16), .word_ready(rdy16), .ccff_head(head16), .ccff_tail(tail16),
      .shift_en(sh16), .rb_data(rb16), .rb_valid(rbv16), .busy(busy16), .done(done16));

   ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u12 (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start12), .word_data(word_data),
      .word_valid(wv12), .word_ready(rdy12), .ccff_head(head12), .ccff_tail(tail12),
      .shift_en(sh12), .rb_data(rb12), .rb_valid(rbv12), .busy(busy12), .done(done12));

   // Behavioural configuration chains: advance on shift_en, tail is the oldest bit.
   always @(posedge prog_clk) begin
      if (sh16) chain16 <= {chain16[14:0], head16};
      if (sh12) chain12 <= {chain12[10:0], head12};
   end
   assign tail16 = chain16[15];
   assign tail12 = chain12[11];

   logic       m_ready, m_head, m_shift, m_rbv, m_busy, m_done;
   logic [7:0] m_rb;
   assign m_ready = sel ? rdy12 : rdy16;
   assign m_head  = sel ? head12 : head16;
   assign m_shift = sel ? sh12 : sh16;
   assign m_rbv   = sel ? rbv12 : rbv16;
   assign m_busy  = sel ? busy12 : busy16;
   assign m_done  = sel ? done12 : done16;
   assign m_rb    = sel ? rb12 : rb16;

   typedef struct {
      logic        sel;
      logic [7:0]  w0, w1;
      int          stall;     // idle cycles inserted after the first word's 8 shifts
      logic        restart;   // pulse start again mid-load
      logic        chk_rb;
      logic [15:0] exp_bits;
      logic [7:0]  exp_rb0, exp_rb1;
   } load_t;

   load_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic load_t mk(input logic s, input logic [7:0] a, input logic [7:0] b, input int st,
                                input logic rs, input logic crb, input logic [15:0] eb,
                                input logic [7:0] r0, input logic [7:0] r1);
      load_t l;
      l.sel = s; l.w0 = a; l.w1 = b; l.stall = st; l.restart = rs; l.chk_rb = crb;
      l.exp_bits = eb; l.exp_rb0 = r0; l.exp_rb1 = r1;
      return l;
   endfunction

   // Chain image after a load: the first CHAIN_LEN bits of the word stream.
   function automatic logic [15:0] model_bits(input logic s, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] w;
      w = {a, b};
      return s ? (w >> 4) : w;
   endfunction

   // Readback of a previous chain image as two left-aligned words.
   function automatic logic [15:0] model_rb(input logic s, input logic [15:0] prev);
      return s ? (prev << 4) : prev;
   endfunction

   task automatic run_load(input load_t r);
      int n, cyc, acc, acc0_cyc, nshift, first_sh, gap, dones, done_cyc, stall_left, busy_err;
      logic        rb_at_done;
      logic [15:0] got;
      logic [7:0]  rbq[$];
      n = r.sel ? 12 : 16;
      cyc = 0; acc = 0; acc0_cyc = -100; nshift = 0; first_sh = -1; gap = 0;
      dones = 0; done_cyc = -1; stall_left = r.stall; busy_err = 0; rb_at_done = 1'b0; got = '0;
      @(negedge prog_clk);
      sel = r.sel; start = 1'b1; word_valid = 1'b0;
      while (cyc < 300 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
         @(negedge prog_clk);
         cyc++;
         start = r.restart && (cyc == 6);
         if (m_shift) begin
            got = {got[14:0], m_head};
            if (nshift == 0) first_sh = cyc;
            nshift++;
            if (!m_busy) busy_err++;
         end else if (nshift > 0 && nshift < n) begin
            gap++;
         end
         if (m_rbv) rbq.push_back(m_rb);
         if (m_done) begin
            dones++;
            done_cyc = cyc;
            rb_at_done = m_rbv;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1 && m_busy) busy_err++;
         // Keep offering (0xEE once both words are in) so surplus words would be visible if consumed.
         if (acc == 1 && r.stall > 0 && (nshift < 8 || stall_left > 0)) begin
            if (nshift >= 8) stall_left--;
            word_valid = 1'b0;
         end else begin
            word_valid = 1'b1;
            word_data  = (acc == 0) ? r.w0 : (acc == 1) ? r.w1 : 8'hEE;
         end
         if (word_valid && m_ready) begin
            if (acc == 0) acc0_cyc = cyc;
            acc++;
         end
      end
      word_valid = 1'b0;
      chk("load_done_seen", (done_cyc >= 0), 1);
      chk("shift_count", nshift, n);
      chk("head_bits", got, r.exp_bits);
      chk("words_accepted", acc, 2);
      chk("first_shift_latency", first_sh - acc0_cyc, 1);
      chk("stall_gap", gap, r.stall);
      chk("done_pulses", dones, 1);
      chk("rb_with_done", rb_at_done, 1);
      chk("busy_profile", busy_err, 0);
      chk("rb_count", rbq.size(), 2);
      if (r.chk_rb && rbq.size() == 2) begin
         chk("rb_word0", rbq[0], r.exp_rb0);
         chk("rb_word1", rbq[1], r.exp_rb1);
      end
      chk("chain_image", r.sel ? {4'h0, chain12} : chain16, r.exp_bits);
   endtask

   initial begin
      logic [15:0] prev16, prev12, eb, erb;
      logic        s;
      logic [7:0]  a, b;
      int          st, k, ns, acc;

      // Fixed vectors; expectations derived by hand from the chain behaviour.
      tbl.push_back(mk(1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b1, 16'hA53C, 8'h00, 8'h00));
      tbl.push_back(mk(1'b0, 8'h12, 8'h34, 0, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h3C));
      tbl.push_back(mk(1'b0, 8'h56, 8'h78, 5, 1'b0, 1'b1, 16'h5678, 8'h12, 8'h34));
      tbl.push_back(mk(1'b1, 8'hF0, 8'hAB, 0, 1'b0, 1'b1, 16'h0F0A, 8'h00, 8'h00));
      tbl.push_back(mk(1'b1, 8'h5C, 8'h3E, 0, 1'b0, 1'b1, 16'h05C3, 8'hF0, 8'hA0));
      prev16 = 16'h5678;
      prev12 = 16'h05C3;
      // Random words, expectations from the reference model.
      for (int i = 0; i < 8; i++) begin
         s   = i[0];
         a   = 8'($urandom_range(255));
         b   = 8'($urandom_range(255));
         st  = ($urandom_range(1) == 1) ? 3 : 0;
         eb  = model_bits(s, a, b);
         erb = model_rb(s, s ? prev12 : prev16);
         tbl.push_back(mk(s, a, b, st, 1'b0, 1'b1, eb, erb[15:8], erb[7:0]));
         if (s) prev12 = eb;
         else   prev16 = eb;
      end

      #2;
      chk("reset_outputs_16", {rdy16, head16, sh16, rb16, rbv16, busy16, done16}, 0);
      chk("reset_outputs_12", {rdy12, head12, sh12, rb12, rbv12, busy12, done12}, 0);
      @(negedge prog_clk);
      prog_reset = 1'b1;

      // Words offered while idle must be ignored.
      for (int i = 0; i < 4; i++) begin
         @(negedge prog_clk);
         word_valid = 1'b1;
         word_data  = 8'h77;
         #1;
         chk("idle_ignores_words", {m_ready, m_shift, m_busy}, 0);
      end
      word_valid = 1'b0;

      for (int i = 0; i < tbl.size(); i++) run_load(tbl[i]);

      // Reset mid-load after five shifts.
      @(negedge prog_clk);
      sel = 1'b0; start = 1'b1;
      k = 0; ns = 0; acc = 0;
      while (ns < 5 && k < 100) begin
         @(negedge prog_clk);
         k++;
         start = 1'b0;
         if (sh16) ns++;
         if (ns < 5) begin
            word_valid = 1'b1;
            word_data  = (acc == 0) ? 8'h9A : 8'hBC;
            if (rdy16) acc++;
         end
      end
      chk("reset_seq_reached_5_shifts", ns, 5);
      prog_reset = 1'b0;
      #1;
      chk("midload_reset_outputs", {rdy16, head16, sh16, rb16, rbv16, busy16, done16}, 0);
      word_valid = 1'b0;
      @(negedge prog_clk);
      chk("no_done_during_reset", done16, 0);
      prog_reset = 1'b1;
      @(negedge prog_clk);
      chk("idle_after_reset", {busy16, sh16}, 0);
      run_load(mk(1'b0, 8'h9A, 8'hBC, 0, 1'b0, 1'b0, 16'h9ABC, 8'h00, 8'h00));
      run_load(mk(1'b0, 8'h11, 8'h22, 0, 1'b0, 1'b1, 16'h1122, 8'h9A, 8'hBC));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
